// File: rtl/hwpe_vec_engine.sv
// Elementwise integer vector engine: joins NB_OPERANDS source streams, applies
// one of eight ops per element and returns results through a stallable pipeline.
module hwpe_vec_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int NB_OPERANDS = 2,
  parameter int PIPE_STAGES = 2,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              start_i,
  input  logic [2:0]                        op_i,
  input  logic [LEN_WIDTH-1:0]              len_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [LEN_WIDTH-1:0]              cnt_o,
  input  logic [NB_OPERANDS-1:0]            src_valid_i,
  input  logic [NB_OPERANDS*DATA_WIDTH-1:0] src_data_i,
  output logic [NB_OPERANDS-1:0]            src_ready_o,
  output logic                              sink_valid_o,
  output logic [DATA_WIDTH-1:0]             sink_data_o,
  input  logic                              sink_ready_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = LEN_WIDTH'(0);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_MIN = 3'd3;
  localparam logic [2:0] OP_MAX = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic [2:0]              op_r;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [LEN_WIDTH-1:0]    acc_cnt_r;
  logic [LEN_WIDTH-1:0]    cnt_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    valid_r [PIPE_STAGES];
  logic [DATA_WIDTH-1:0]   data_r  [PIPE_STAGES];

  logic                    advance_s;
  logic                    fire_s;
  logic                    sink_hs_s;
  logic                    last_acc_s;
  logic                    last_res_s;
  logic                    start_s;
  logic                    done_set_s;
  logic [NB_OPERANDS-1:0]  src_ready_s;
  logic [DATA_WIDTH-1:0]   result_s;

  // Folds all operands with the selected op; MUL only uses the first two.
  function automatic logic [DATA_WIDTH-1:0] vec_op(
    input logic [2:0]                        op,
    input logic [NB_OPERANDS*DATA_WIDTH-1:0] src
  );
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] opnd;
    acc = src[0 +: DATA_WIDTH];
    for (int k = 1; k < NB_OPERANDS; k++) begin
      opnd = src[k*DATA_WIDTH +: DATA_WIDTH];
      case (op)
        OP_ADD:  acc = acc + opnd;
        OP_SUB:  acc = acc - opnd;
        OP_MUL:  acc = (k == 1) ? acc * opnd : acc;
        OP_MIN:  acc = ($signed(opnd) < $signed(acc)) ? opnd : acc;
        OP_MAX:  acc = ($signed(opnd) > $signed(acc)) ? opnd : acc;
        OP_AND:  acc = acc & opnd;
        OP_OR:   acc = acc | opnd;
        OP_XOR:  acc = acc ^ opnd;
        default: acc = acc;
      endcase
    end
    return acc;
  endfunction

  // The whole pipeline stalls only when its last stage is full and not taken.
  assign advance_s  = !valid_r[PIPE_STAGES-1] || sink_ready_i;
  assign fire_s     = (state_r == RUN) && (&src_valid_i) && advance_s && !clear_i;
  assign sink_hs_s  = valid_r[PIPE_STAGES-1] && sink_ready_i;
  assign last_acc_s = fire_s && ((acc_cnt_r + LEN_ONE) == len_r);
  assign last_res_s = sink_hs_s && ((cnt_r + LEN_ONE) == len_r);
  assign start_s    = (state_r == IDLE) && start_i && !clear_i;
  assign result_s   = vec_op(op_r, src_data_i);

  // FSM state register plus the registered busy/done flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (clear_i) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= done_set_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i && (len_i != LEN_ZERO)) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_acc_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (last_res_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: source ready and the done request for the following cycle.
  always_comb begin
    done_set_s  = 1'b0;
    src_ready_s = {NB_OPERANDS{1'b0}};
    case (state_r)
      IDLE: begin
        done_set_s  = start_i && (len_i == LEN_ZERO);
        src_ready_s = {NB_OPERANDS{1'b0}};
      end
      RUN: begin
        done_set_s  = 1'b0;
        src_ready_s = {NB_OPERANDS{fire_s}};
      end
      DRAIN: begin
        done_set_s  = last_res_s;
        src_ready_s = {NB_OPERANDS{1'b0}};
      end
      default: begin
        done_set_s  = 1'b0;
        src_ready_s = {NB_OPERANDS{1'b0}};
      end
    endcase
  end

  // Job parameters and the accepted / delivered element counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_r      <= 3'd0;
      len_r     <= LEN_ZERO;
      acc_cnt_r <= LEN_ZERO;
      cnt_r     <= LEN_ZERO;
    end else if (clear_i) begin
      op_r      <= 3'd0;
      len_r     <= LEN_ZERO;
      acc_cnt_r <= LEN_ZERO;
      cnt_r     <= LEN_ZERO;
    end else if (start_s) begin
      op_r      <= op_i;
      len_r     <= len_i;
      acc_cnt_r <= LEN_ZERO;
      cnt_r     <= LEN_ZERO;
    end else begin
      if (fire_s) begin
        acc_cnt_r <= acc_cnt_r + LEN_ONE;
      end
      if (sink_hs_s) begin
        cnt_r <= cnt_r + LEN_ONE;
      end
    end
  end

  // Result pipeline; stage 0 captures the computed element on a fire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        valid_r[i] <= 1'b0;
        data_r[i]  <= {DATA_WIDTH{1'b0}};
      end
    end else if (clear_i) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        valid_r[i] <= 1'b0;
        data_r[i]  <= {DATA_WIDTH{1'b0}};
      end
    end else if (advance_s) begin
      valid_r[0] <= fire_s;
      if (fire_s) begin
        data_r[0] <= result_s;
      end
      for (int i = 1; i < PIPE_STAGES; i++) begin
        valid_r[i] <= valid_r[i-1];
        data_r[i]  <= data_r[i-1];
      end
    end
  end

  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign cnt_o        = cnt_r;
  assign src_ready_o  = src_ready_s;
  assign sink_valid_o = valid_r[PIPE_STAGES-1];
  assign sink_data_o  = data_r[PIPE_STAGES-1];

endmodule
